// File: rtl/regfile_scoreboard.sv
// Register scoreboard between issue and the RV32I register file: tracks pending
// destination writes, stalls issue on RAW/WAW hazards and drives the regfile write port.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [4:0]          issue_rs1,
  input  logic [4:0]          issue_rs2,
  input  logic [4:0]          issue_rd,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  logic                issue_wr_rd,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic [31:0]         wb_data,
  input  logic                flush,
  output logic                RegWrite,
  output logic [4:0]          rd,
  output logic [31:0]         rd_write_data,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic                wb_err
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] rs1_oh, rs2_oh, rd_oh, wb_oh;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_REGS-1:0] wb_clr, issue_set;
  logic                hazard;
  logic                accept;
  logic                wb_stray;

  // One-hot decode that never selects x0, so x0 can neither hazard nor go busy.
  function automatic logic [NUM_REGS-1:0] decode(input logic [4:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == 5'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  always_comb begin
    rs1_oh = decode(issue_rs1);
    rs2_oh = decode(issue_rs2);
    rd_oh  = decode(issue_rd);
    wb_oh  = decode(wb_rd);
  end

  assign RegWrite      = wb_valid;
  assign rd            = wb_rd;
  assign rd_write_data = wb_data;

  assign wb_clr   = wb_valid ? wb_oh : '0;
  assign eff_busy = busy_q & ~wb_clr;

  assign hazard = (issue_use_rs1 && |(eff_busy & rs1_oh)) ||
                  (issue_use_rs2 && |(eff_busy & rs2_oh)) ||
                  (issue_wr_rd   && |(eff_busy & rd_oh));

  assign issue_ready = issue_valid && !hazard && !flush;
  assign accept      = issue_valid && issue_ready;
  assign issue_set   = (accept && issue_wr_rd) ? rd_oh : '0;

  // wb_oh excludes x0, so writebacks to x0 are never flagged.
  assign wb_stray = wb_valid && |(wb_oh & ~busy_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~wb_clr) | issue_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_err <= 1'b0;
    end else if (wb_stray && !flush) begin
      wb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench: write-port results are queued when a writeback is driven
// and popped by a monitor; hazard/busy/stat expectations are checked inline per task.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_use_rs1, issue_use_rs2, issue_wr_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        reg_write;
  logic [4:0]  rd_o;
  logic [31:0] rd_data_o;
  logic [31:0] busy;
  logic [31:0] stall_cnt;
  logic        wb_err;

  // Narrow-counter instance used for saturation
  logic        rst4_n;
  logic        v4, rdy4;
  logic [4:0]  rs1_4, rd_4;
  logic        use1_4, wr_4;
  logic        rw4;
  logic [4:0]  rdo4;
  logic [31:0] rdd4;
  logic [31:0] busy4;
  logic [3:0]  stall4;
  logic        err4;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] wb_q[$];
  int exp_stall;

  always #5 clk = ~clk;

  regfile_scoreboard #(.NUM_REGS(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .issue_wr_rd(issue_wr_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .RegWrite(reg_write), .rd(rd_o), .rd_write_data(rd_data_o),
    .busy(busy), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  regfile_scoreboard #(.NUM_REGS(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n),
    .issue_valid(v4), .issue_ready(rdy4),
    .issue_rs1(rs1_4), .issue_rs2(5'd0), .issue_rd(rd_4),
    .issue_use_rs1(use1_4), .issue_use_rs2(1'b0), .issue_wr_rd(wr_4),
    .wb_valid(1'b0), .wb_rd(5'd0), .wb_data(32'd0), .flush(1'b0),
    .RegWrite(rw4), .rd(rdo4), .rd_write_data(rdd4),
    .busy(busy4), .stall_cnt(stall4), .wb_err(err4)
  );

  // Write-port monitor: every RegWrite cycle must match the oldest queued writeback.
  always @(negedge clk) begin
    if (rst_n && reg_write) begin
      n_vec++;
      if (wb_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_port: RegWrite=1 rd=%0d with no writeback expected", rd_o);
      end else begin
        logic [36:0] e;
        e = wb_q.pop_front();
        if ({rd_o, rd_data_o} !== e)
          begin
            n_err++;
            $display("FAIL wr_port: got rd=%0d data=%h, expected rd=%0d data=%h",
                     rd_o, rd_data_o, e[36:32], e[31:0]);
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] d, input logic w);
    issue_valid = 1; issue_rs1 = r1; issue_use_rs1 = u1;
    issue_rs2 = r2; issue_use_rs2 = u2; issue_rd = d; issue_wr_rd = w;
  endtask

  task automatic writeback(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1; wb_rd = r; wb_data = d;
    wb_q.push_back({r, d});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #1;
    if (busy !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h expected 0", busy); end
    n_vec++;
    if (stall_cnt !== 32'h0) begin n_err++; $display("FAIL reset_stall: got %h expected 0", stall_cnt); end
    n_vec++;
    if (wb_err !== 1'b0) begin n_err++; $display("FAIL reset_wb_err: got %b expected 0", wb_err); end
    n_vec++;
    if (issue_ready !== 1'b0 || reg_write !== 1'b0) begin
      n_err++; $display("FAIL reset_outs: ready=%b RegWrite=%b expected 0 0", issue_ready, reg_write);
    end
    n_vec++;
    tick(); tick();
    rst_n = 1;
    tick();
    exp_stall = 0;
  endtask

  task automatic test_raw_stall();
    issue(5'd0, 0, 5'd0, 0, 5'd5, 1);
    @(negedge clk);
    chk("raw_issue_ready", 32'(issue_ready), 32'd1);
    tick();
    chk("raw_busy5", busy, 32'h0000_0020);
    issue(5'd5, 1, 5'd0, 0, 5'd0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("raw_stall_ready", 32'(issue_ready), 32'd0);
      tick();
      exp_stall++;
      chk("raw_stall_cnt", stall_cnt, 32'(exp_stall));
    end
    idle();
  endtask

  task automatic test_wb_bypass();
    writeback(5'd5, 32'hDEAD_BEEF);
    issue(5'd5, 1, 5'd0, 0, 5'd0, 0);
    @(negedge clk);
    chk("bypass_ready", 32'(issue_ready), 32'd1);
    tick();
    idle();
    chk("bypass_busy_clr", busy, 32'h0);
    chk("bypass_wb_err", 32'(wb_err), 32'd0);
  endtask

  task automatic test_x0();
    issue(5'd0, 1, 5'd0, 1, 5'd0, 1);
    @(negedge clk);
    chk("x0_ready", 32'(issue_ready), 32'd1);
    tick();
    chk("x0_busy", busy, 32'h0);
    chk("x0_ready_again", 32'(issue_ready), 32'd1);
    tick();
    idle();
    chk("x0_stall_cnt", stall_cnt, 32'(exp_stall));
  endtask

  task automatic test_waw();
    issue(5'd0, 0, 5'd0, 0, 5'd7, 1);
    tick();
    chk("waw_busy7", busy, 32'h0000_0080);
    @(negedge clk);
    chk("waw_stall_ready", 32'(issue_ready), 32'd0);
    tick();
    exp_stall++;
    chk("waw_stall_cnt", stall_cnt, 32'(exp_stall));
    writeback(5'd7, 32'h1234_5678);
    @(negedge clk);
    chk("waw_same_cycle_ready", 32'(issue_ready), 32'd1);
    tick();
    idle();
    chk("waw_set_wins", busy, 32'h0000_0080);
    chk("waw_wb_err", 32'(wb_err), 32'd0);
    writeback(5'd7, 32'h0000_0007);
    tick();
    idle();
    chk("waw_drain", busy, 32'h0);
  endtask

  task automatic test_flush();
    issue(5'd0, 0, 5'd0, 0, 5'd3, 1);
    tick();
    issue(5'd0, 0, 5'd0, 0, 5'd9, 1);
    tick();
    idle();
    chk("flush_pre_busy", busy, 32'h0000_0208);
    flush = 1;
    issue(5'd0, 0, 5'd0, 0, 5'd1, 1);
    writeback(5'd3, 32'hCAFE_0003);
    @(negedge clk);
    chk("flush_ready", 32'(issue_ready), 32'd0);
    tick();
    idle();
    exp_stall++;
    chk("flush_busy", busy, 32'h0);
    chk("flush_wb_err", 32'(wb_err), 32'd0);
    chk("flush_stall_cnt", stall_cnt, 32'(exp_stall));
    writeback(5'd3, 32'hBAD0_0003);
    tick();
    idle();
    chk("stray_wb_err", 32'(wb_err), 32'd1);
    tick(); tick();
    chk("wb_err_sticky", 32'(wb_err), 32'd1);
  endtask

  task automatic test_async_reset();
    issue(5'd0, 0, 5'd0, 0, 5'd12, 1);
    tick();
    issue(5'd0, 0, 5'd12, 1, 5'd0, 0);
    tick();
    chk("ar_pre_busy", busy, 32'h0000_1000);
    #2 rst_n = 0;
    #1;
    chk("ar_busy", busy, 32'h0);
    chk("ar_stall", stall_cnt, 32'h0);
    chk("ar_wb_err", 32'(wb_err), 32'd0);
    idle();
    tick();
    rst_n = 1;
    writeback(5'd4, 32'h4444_4444);
    tick();
    idle();
    chk("post_reset_wb_err", 32'(wb_err), 32'd1);
  endtask

  task automatic test_saturation();
    v4 = 1; rs1_4 = 0; use1_4 = 0; rd_4 = 5'd5; wr_4 = 1;
    tick();
    chk("sat_busy", busy4, 32'h0000_0020);
    rs1_4 = 5'd5; use1_4 = 1; rd_4 = 0; wr_4 = 0;
    for (int k = 0; k < 14; k++) tick();
    chk("sat_cnt_14", 32'(stall4), 32'hE);
    tick();
    chk("sat_cnt_15", 32'(stall4), 32'hF);
    for (int k = 0; k < 5; k++) tick();
    chk("sat_hold", 32'(stall4), 32'hF);
    chk("sat_ready", 32'(rdy4), 32'd0);
    #2 rst4_n = 0;
    #1;
    chk("sat_ar_cnt", 32'(stall4), 32'h0);
    chk("sat_ar_busy", busy4, 32'h0);
    v4 = 0; use1_4 = 0;
    tick();
    rst4_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst4_n = 0; v4 = 0; rs1_4 = 0; rd_4 = 0; use1_4 = 0; wr_4 = 0;
    test_reset();
    rst4_n = 1;
    test_raw_stall();
    test_wb_bypass();
    test_x0();
    test_waw();
    test_flush();
    test_async_reset();
    test_saturation();
    tick();
    chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
